// File: rtl/fsm_generador_secuencia.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated reps times.
// Optional separator bit between repetitions when FSM_GEN_GAP_EN is defined.
module fsm_generador_secuencia #(
    parameter int WIDTH      = 8,
    parameter int BIT_CYCLES = 1,
    parameter int REP_W      = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           pattern,
    input  logic [$clog2(WIDTH):0]     len,
    input  logic [REP_W-1:0]           reps,
    output logic                       x_out,
    output logic                       valid,
    output logic                       busy,
    output logic                       done
);
    localparam int LW = $clog2(WIDTH) + 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int HW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(BIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    idx;
    logic [HW-1:0]    hold;
    logic [REP_W-1:0] reps_q;
    logic [REP_W-1:0] rep_cnt;

    logic [LW-1:0]    len_eff;
    logic [REP_W-1:0] reps_eff;
    logic [IW-1:0]    first_idx;

    always_comb begin
        len_eff   = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;
        reps_eff  = (reps == '0) ? REP_W'(1) : reps;
        first_idx = IW'(len_eff - LW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pat_q    <= '0;
            last_idx <= '0;
            idx      <= '0;
            hold     <= '0;
            reps_q   <= '0;
            rep_cnt  <= '0;
            x_out    <= 1'b0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_q    <= pattern;
                        reps_q   <= reps_eff;
                        last_idx <= first_idx;
                        idx      <= first_idx;
                        hold     <= '0;
                        rep_cnt  <= REP_W'(1);
                        if (len_eff == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            x_out <= pattern[first_idx];
                            valid <= 1'b1;
                            busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (hold != HOLD_MAX) begin
                        hold <= hold + HW'(1);
                    end else begin
                        hold <= '0;
                        if (idx != '0) begin
                            idx   <= idx - IW'(1);
                            x_out <= pat_q[idx - IW'(1)];
                        end else if (rep_cnt < reps_q) begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                            idx     <= last_idx;
`ifdef FSM_GEN_GAP_EN
                            state   <= GAP;
                            x_out   <= 1'b0;
                            valid   <= 1'b0;
`else
                            x_out   <= pat_q[last_idx];
`endif
                        end else begin
                            state <= DONE;
                            x_out <= 1'b0;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
`ifdef FSM_GEN_GAP_EN
                // Separator period; idx already reloaded for the next repetition
                GAP: begin
                    if (hold != HOLD_MAX) begin
                        hold <= hold + HW'(1);
                    end else begin
                        hold  <= '0;
                        state <= SHIFT;
                        x_out <= pat_q[idx];
                        valid <= 1'b1;
                    end
                end
`endif
                DONE: begin
                    state   <= IDLE;
                    done    <= 1'b0;
                    x_out   <= 1'b0;
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    hold    <= '0;
                    idx     <= '0;
                    rep_cnt <= '0;
                end
                default: begin
                    state <= IDLE;
                    x_out <= 1'b0;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    hold  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsm_generador_secuencia.sv
// Scoreboard bench for fsm_generador_secuencia: two instances (BIT_CYCLES=1 and 3).
// Expected bit/done events are queued at start; a negedge monitor pops and compares.
module tb_fsm_generador_secuencia;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [2];
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] reps = '0;
    logic       x [2];
    logic       v [2];
    logic       b [2];
    logic       d [2];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int zc     = 0;
    logic [3:0] sh = '0;

    typedef struct {
        int   c;
        logic bit_v;
    } ev_t;

    ev_t bq [2][$];
    int  dq [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fsm_generador_secuencia #(.WIDTH(8), .BIT_CYCLES(1), .REP_W(4)) u0 (
        .clk(clk), .rst(rst), .start(start[0]), .pattern(pattern),
        .len(len), .reps(reps), .x_out(x[0]), .valid(v[0]),
        .busy(b[0]), .done(d[0])
    );

    fsm_generador_secuencia #(.WIDTH(8), .BIT_CYCLES(3), .REP_W(4)) u1 (
        .clk(clk), .rst(rst), .start(start[1]), .pattern(pattern),
        .len(len), .reps(reps), .x_out(x[1]), .valid(v[1]),
        .busy(b[1]), .done(d[1])
    );

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", n, act, exp, cyc);
        end
    endtask

    // Monitor: compares every valid/done cycle against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (v[i]) begin
                    if (bq[i].size() == 0) begin
                        chk($sformatf("unexpected_valid%0d", i), 1, 0);
                    end else begin
                        ev_t e;
                        e = bq[i].pop_front();
                        chk($sformatf("bit%0d", i), int'(x[i]), int'(e.bit_v));
                        chk($sformatf("bit_cycle%0d", i), cyc, e.c);
                        chk($sformatf("busy_valid%0d", i), int'(b[i]), 1);
                    end
                end else if (x[i]) begin
                    chk($sformatf("x_idle%0d", i), int'(x[i]), 0);
                end
                if (d[i]) begin
                    if (dq[i].size() == 0) begin
                        chk($sformatf("extra_done%0d", i), 1, 0);
                    end else begin
                        chk($sformatf("done_cycle%0d", i), cyc, dq[i].pop_front());
                        chk($sformatf("busy_done%0d", i), int'(b[i]), 0);
                        chk($sformatf("valid_done%0d", i), int'(v[i]), 0);
                    end
                end
            end
            sh = {sh[2:0], x[0]};
            if (sh == 4'b1011) zc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_exp(input int i, input int a, input logic [7:0] p,
                            input int l, input int r, input int bc);
        int le, re, t;
        le = (l > 8) ? 8 : l;
        re = (r == 0) ? 1 : r;
        t  = 0;
        if (le > 0) begin
            for (int k = 0; k < re; k++) begin
`ifdef FSM_GEN_GAP_EN
                if (k > 0) t += bc;
`endif
                for (int j = le - 1; j >= 0; j--) begin
                    for (int h = 0; h < bc; h++) begin
                        ev_t e;
                        e.c     = a + t;
                        e.bit_v = p[j];
                        bq[i].push_back(e);
                        t++;
                    end
                end
            end
        end
        dq[i].push_back(a + t);
    endtask

    task automatic go(input int i, input logic [7:0] p, input int l, input int r);
        pattern  = p;
        len      = 4'(l);
        reps     = 4'(r);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
        pattern  = 8'hFF;
        len      = 4'd2;
        reps     = 4'd7;
        push_exp(i, cyc, p, l, r, (i == 0) ? 1 : 3);
    endtask

    task automatic wait_idle(input int i);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (bq[i].size() == 0 && dq[i].size() == 0 && !b[i] && !d[i]) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk($sformatf("timeout%0d", i), 1, 0);
        step();
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset_x", int'(x[i]), 0);
            chk("reset_valid", int'(v[i]), 0);
            chk("reset_busy", int'(b[i]), 0);
            chk("reset_done", int'(d[i]), 0);
        end
        step();

        // Basic, reps=1
        go(0, 8'h0B, 4, 1);
        wait_idle(0);
        // Repetitions
        go(0, 8'h0B, 4, 2);
        chk("busy_after_accept", int'(b[0]), 1);
        wait_idle(0);
        // Hold and clamping on BIT_CYCLES=3 instance
        go(1, 8'hA5, 15, 0);
        wait_idle(1);
        // len=0
        go(0, 8'h5A, 0, 3);
        wait_idle(0);
        // Re-pulsed start during transfer (cycles 2 and 5)
        go(0, 8'h0B, 4, 1);
        step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_idle(0);
        chk("no_retrigger_busy", int'(b[0]), 0);

        // Mid-transfer reset at cycle 2, restart at cycle 4
        go(0, 8'h0B, 4, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        bq[0].delete();
        dq[0].delete();
        chk("rst_x", int'(x[0]), 0);
        chk("rst_valid", int'(v[0]), 0);
        chk("rst_busy", int'(b[0]), 0);
        chk("rst_done", int'(d[0]), 0);
        step();
        go(0, 8'h0B, 4, 1);
        wait_idle(0);

        // Other patterns
        go(0, 8'hC3, 8, 1);
        wait_idle(0);
        go(1, 8'h06, 3, 2);
        wait_idle(1);

        // Closed loop: one 1011 detection per repetition
        step();
        zc = 0;
        go(0, 8'h0B, 4, 3);
        wait_idle(0);
        chk("detect_count", zc, 3);

        chk("q_empty0", bq[0].size() + dq[0].size(), 0);
        chk("q_empty1", bq[1].size() + dq[1].size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
